// File: rtl/matmul_run_ctrl.sv
// Run controller for the 3x3 matmul program: steps pc to HALT_PC, snapshots the
// nine result words, then streams them row-major over valid/ready.
module matmul_run_ctrl #(
  parameter logic [31:0] HALT_PC = 32'd356,
  parameter logic [31:0] PC_STEP = 32'd4,
  parameter int          DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   pc,
  input  logic [DW-1:0] d11,
  input  logic [DW-1:0] d12,
  input  logic [DW-1:0] d13,
  input  logic [DW-1:0] d21,
  input  logic [DW-1:0] d22,
  input  logic [DW-1:0] d23,
  input  logic [DW-1:0] d31,
  input  logic [DW-1:0] d32,
  input  logic [DW-1:0] d33,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [3:0]    res_idx,
  output logic          res_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [DW-1:0]   snap_q [9];
  logic [DW-1:0]   snap_d [9];
  logic [3:0]      idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!stall) begin
          if (pc_q != HALT_PC) begin
            pc_d = pc_q + PC_STEP;
          end else begin
            snap_d[0] = d11;
            snap_d[1] = d12;
            snap_d[2] = d13;
            snap_d[3] = d21;
            snap_d[4] = d22;
            snap_d[5] = d23;
            snap_d[6] = d31;
            snap_d[7] = d32;
            snap_d[8] = d33;
            idx_d     = '0;
            valid_d   = 1'b1;
            // word 0 is presented straight from the input being captured
            data_d    = d11;
            state_d   = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (valid_q && res_ready) begin
          if (idx_q == 4'd8) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            idx_d   = '0;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = snap_q[idx_q + 4'd1];
          end
        end
      end

      S_DONE: begin
        pc_d = HALT_PC;
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < 9; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      for (int i = 0; i < 9; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign pc        = pc_q;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_idx   = idx_q;
  assign res_last  = valid_q && (idx_q == 4'd8);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_matmul_run_ctrl.sv
// Directed bench for matmul_run_ctrl: basic run, stall, backpressure, snapshot
// isolation, ignored/restart start and asynchronous reset mid-run / mid-drain.
module tb_matmul_run_ctrl;

  localparam logic [31:0] HALT = 32'd356;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        res_ready;
  logic [31:0] pc;
  logic [31:0] d [9];
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_idx;
  logic        res_last;
  logic        busy;
  logic        done;

  logic        ovr;
  logic [31:0] seed;
  int          n_cmp;
  int          n_err;

  matmul_run_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .pc        (pc),
    .d11       (d[0]),
    .d12       (d[1]),
    .d13       (d[2]),
    .d21       (d[3]),
    .d22       (d[4]),
    .d23       (d[5]),
    .d31       (d[6]),
    .d32       (d[7]),
    .d33       (d[8]),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for main: results are a combinational function of pc
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      d[i] = ovr ? 32'hDEADBEEF : (pc ^ (seed + i * 32'h01010101));
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] s, input int i);
    return HALT ^ (s + i * 32'h01010101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int acc;
    int cyc;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    res_ready = 1'b1;
    ovr       = 1'b0;
    seed      = 32'h10000000;

    // reset state
    #3;
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_idx", {28'd0, res_idx}, 32'd0);
    chk("rst_last", {31'd0, res_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_pc", pc, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // basic run
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run1_pc0", pc, 32'd0);
    chk("run1_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 89; k++) begin
      step();
      chk("run1_pc", pc, k * 4);
    end
    chk("run1_novalid", {31'd0, res_valid}, 32'd0);
    step();
    chk("run1_cap_valid", {31'd0, res_valid}, 32'd1);
    ovr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("run1_valid", {31'd0, res_valid}, 32'd1);
      chk("run1_idx", {28'd0, res_idx}, i);
      chk("run1_data", res_data, exp_word(seed, i));
      chk("run1_last", {31'd0, res_last}, (i == 8) ? 32'd1 : 32'd0);
      step();
    end
    chk("run1_done_at_100", {31'd0, done}, 32'd1);
    chk("run1_valid_off", {31'd0, res_valid}, 32'd0);
    chk("run1_busy_off", {31'd0, busy}, 32'd0);
    chk("run1_done_pc", pc, HALT);

    // restart from DONE, start ignored in RUN, stall at pc=200
    ovr  = 1'b0;
    seed = 32'h22220000;
    start = 1'b1;
    step();
    start = 1'b0;
    e = 1;
    chk("run2_pc0", pc, 32'd0);
    chk("run2_done_clr", {31'd0, done}, 32'd0);
    while (pc != 32'd200 && e < 200) begin
      start = (pc == 32'd40);
      step();
      e++;
    end
    start = 1'b0;
    chk("run2_pc200_edge", e, 51);
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      e++;
      chk("run2_stall_pc", pc, 32'd200);
    end
    stall = 1'b0;
    while (!res_valid && e < 300) begin
      step();
      e++;
    end
    chk("run2_capture_edge", e, 96);
    ovr = 1'b1;

    // backpressure drain, start pulse ignored in DRAIN
    acc = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      res_ready = (cyc % 2 == 0);
      start     = (cyc == 3);
      chk("run2_valid", {31'd0, res_valid}, 32'd1);
      chk("run2_idx", {28'd0, res_idx}, acc);
      chk("run2_data", res_data, exp_word(seed, (acc < 9) ? acc : 0));
      chk("run2_last", {31'd0, res_last}, (acc == 8) ? 32'd1 : 32'd0);
      if (res_ready) acc++;
      step();
      cyc++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    chk("run2_drain_cycles", cyc, 17);
    chk("run2_accepts", acc, 9);
    chk("run2_done", {31'd0, done}, 32'd1);

    // async reset in RUN at pc=120
    ovr  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    e = 0;
    while (pc != 32'd120 && e < 200) begin
      step();
      e++;
    end
    chk("run3_pc120", pc, 32'd120);
    #2 rst_n = 1'b0;
    #1;
    chk("run3_rst_pc", pc, 32'd0);
    chk("run3_rst_busy", {31'd0, busy}, 32'd0);
    chk("run3_rst_done", {31'd0, done}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("run3_idle_pc", pc, 32'd0);
    chk("run3_idle_busy", {31'd0, busy}, 32'd0);

    // async reset in DRAIN at res_idx=4
    start = 1'b1;
    step();
    start = 1'b0;
    e = 0;
    while (!(res_valid && res_idx == 4'd4) && e < 200) begin
      step();
      e++;
    end
    chk("run4_idx4", {28'd0, res_idx}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("run4_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("run4_rst_idx", {28'd0, res_idx}, 32'd0);
    chk("run4_rst_data", res_data, 32'd0);
    chk("run4_rst_last", {31'd0, res_last}, 32'd0);
    chk("run4_rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("run4_idle_pc", pc, 32'd0);
    chk("run4_idle_busy", {31'd0, busy}, 32'd0);
    chk("run4_idle_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_run_ctrl.md
# matmul_run_ctrl

Hardware run controller for the 3x3 matrix-multiply program on `main`. It replaces bench-driven PC stepping. On `start` it drives `pc` from 0 upward in steps of `PC_STEP` until `HALT_PC`, then snapshots the nine result words `d11..d33`. It then streams those words out, row-major, over a valid/ready interface to a downstream reader such as a UART dumper or a checker.

## Interface
- `HALT_PC`, 356: final PC value; stepping stops when `pc` equals it. Must be a multiple of `PC_STEP`.
- `PC_STEP`, 4: PC increment per step.
- `DW`, 32: result word width.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a run; sampled only in IDLE or DONE.
- `stall` input 1: while high in RUN, `pc` holds and no capture occurs.
- `pc` output 32: PC presented to `main`.
- `d11..d33` input DW each: result matrix from `main` (nine ports, row-major).
- `res_valid` output 1: `res_data` holds a valid result word.
- `res_ready` input 1: downstream accepts the word.
- `res_data` output DW: current snapshot word.
- `res_idx` output 4: index of the current word, 0..8 (0 = d11, 8 = d33).
- `res_last` output 1: high when `res_idx == 8` and `res_valid` is high.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: high in DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (async, `rst_n` low): state IDLE; `pc=0`, `res_valid=0`, `res_data=0`, `res_idx=0`, `res_last=0`, `busy=0`, `done=0`; snapshot registers cleared.
- IDLE: `pc` holds 0. `start=1` moves to RUN with `pc` loaded to 0.
- RUN, on each edge with `stall=0`:
  - if `pc != HALT_PC`, then `pc <= pc + PC_STEP`, modulo 2^32 with wrap to 0 permitted;
  - if `pc == HALT_PC`, capture all nine `d` inputs into snapshot registers, clear `res_idx` to 0, and move to DRAIN.
- RUN, `stall=1`: no change. `start` is ignored throughout RUN.
- DRAIN:
  - `res_valid=1`; `res_data` = snapshot[`res_idx`].
  - On `res_valid && res_ready`, `res_idx` increments.
  - A handshake at `res_idx == 8` moves to DONE, clears `res_valid` and returns `res_idx` to 0.
  - While `res_ready=0`, `res_data` and `res_idx` stay stable.
  - `start` is ignored.
- DRAIN, snapshot: captured values are frozen; changes on `d11..d33` do not affect the output.
- DONE: `done=1`; `pc` holds `HALT_PC`. `start=1` moves to RUN with `pc` loaded to 0 and `done` cleared on the same edge.
- Reset mid-run or mid-drain: immediate return to the reset values; a partially transmitted result is discarded.

## Timing
- Outputs are registered; `res_last` and `busy`/`done` decode from registered state.
- Start edge E0: `pc=0` is visible after E0. With no stalls, `pc` takes the value `k*PC_STEP` after edge E0+k. `pc=HALT_PC` appears after E0+HALT_PC/PC_STEP, which is E0+89 at defaults.
- Capture edge: the first non-stalled edge with `pc == HALT_PC`, E0+90 at defaults. `res_valid` rises immediately after it.
- Drain with `res_ready` held high: one word per cycle, 9 cycles. DONE follows the edge that accepts word 8.
- Each stall cycle adds exactly one cycle of latency. A start-to-done run is 100 cycles at defaults with no stalls and `res_ready=1`.
- `main` is combinational on `pc`: `d` values sampled at the capture edge reflect `pc == HALT_PC`.

## Test plan
- **Basic run:** reset, then pulse `start` with `res_ready=1`.
  - `pc` reads 0, 4, …, 356.
  - The nine words stream with `res_idx` 0..8 and equal the values on `d11..d33` at the capture edge.
  - `res_last` is high only on index 8.
  - `done` rises 100 cycles after start.
- **Backpressure:** toggle `res_ready` 1/0 every cycle during DRAIN. Each word is held stable while not ready; no word is skipped or duplicated; 9 accepts occur in 17 cycles.
- **Stall:** hold `stall` for 5 cycles when `pc=200`. `pc` stays at 200 for 5 cycles, and the capture edge slips by exactly 5.
- **Snapshot isolation:** change all `d` inputs to 0xDEADBEEF after capture. The streamed data still equals the captured values.
- **Ignored start and restart:** pulse `start` during RUN and during DRAIN, then pulse it in DONE.
  - The pulses in RUN and DRAIN have no effect.
  - The pulse in DONE restarts with `pc=0` and `done=0`.
- **Async reset mid-operation:** assert `rst_n=0` at `pc=120`, and separately at `res_idx=4`.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release the block sits in IDLE with `pc=0` until `start`.
